// File: rtl/keypad_scanner_if.sv
// Keypad-side and decoded-key signals of keypad_scanner, grouped for port use.
// master = scanner side, slave = keypad / consumer side.
interface keypad_scanner_if;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (input row, output col, key_code, key_valid, key_held);
    modport slave  (output row, input col, key_code, key_valid, key_held);
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with press/release debounce and one key_valid strobe per press.
// Define KEYPAD_SCANNER_REPEAT_EN to re-strobe key_valid every REPEAT_CNT cycles while the key is held.
module keypad_scanner #(
    parameter int SCAN_DIV     = 4,
    parameter int DEBOUNCE_CNT = 8,
    parameter int REPEAT_CNT   = 64
) (
    input  logic                clk,
    input  logic                reset,
    keypad_scanner_if.master    kp
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CNT - 1);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2
    } state_t;

    // A pattern is a key only when exactly one line is pulled low.
    function automatic logic single_zero(input logic [3:0] p);
        logic r;
        case (p)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: r = 1'b1;
            default:                            r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic [1:0] zero_idx(input logic [3:0] p);
        logic [1:0] r;
        case (p)
            4'b1110: r = 2'd0;
            4'b1101: r = 2'd1;
            4'b1011: r = 2'd2;
            4'b0111: r = 2'd3;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

    logic [3:0]    row_meta_q, row_s_q;
    state_t        state_q, state_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [3:0]    col_q, col_d;
    logic [3:0]    cap_q, cap_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d;
    logic          key_held_q, key_held_d;
    logic [3:0]    col_next_s;

`ifdef KEYPAD_SCANNER_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CNT + 1);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CNT - 1);
    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
`endif

    assign col_next_s = {col_q[2:0], col_q[3]};

    // Next-state and output decode; cnt is shared by press and release debounce.
    always_comb begin
        state_d     = state_q;
        dwell_d     = dwell_q;
        col_d       = col_q;
        cap_d       = cap_q;
        cnt_d       = cnt_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
`ifdef KEYPAD_SCANNER_REPEAT_EN
        rep_cnt_d   = '0;
`endif
        case (state_q)
            SCAN: begin
                if (dwell_q == DWELL_LAST) begin
                    dwell_d = '0;
                    if (single_zero(row_s_q)) begin
                        state_d = DEBOUNCE;
                        cap_d   = row_s_q;
                        cnt_d   = '0;
                    end else begin
                        col_d = col_next_s;
                    end
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (row_s_q == cap_q) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d     = PRESSED;
                        cnt_d       = '0;
                        key_code_d  = {zero_idx(col_q), zero_idx(cap_q)};
                        key_valid_d = 1'b1;
                        key_held_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    state_d = SCAN;
                    col_d   = col_next_s;
                    dwell_d = '0;
                    cnt_d   = '0;
                end
            end
            PRESSED: begin
`ifdef KEYPAD_SCANNER_REPEAT_EN
                if (row_s_q == cap_q) begin
                    if (rep_cnt_q == REP_LAST) begin
                        key_valid_d = 1'b1;
                        rep_cnt_d   = '0;
                    end else begin
                        rep_cnt_d = rep_cnt_q + 1'b1;
                    end
                end else begin
                    rep_cnt_d = '0;
                end
`endif
                // Any non-idle row (including a second key) restarts release qualification.
                if (row_s_q == 4'b1111) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d    = SCAN;
                        col_d      = col_next_s;
                        dwell_d    = '0;
                        cnt_d      = '0;
                        key_held_d = 1'b0;
`ifdef KEYPAD_SCANNER_REPEAT_EN
                        rep_cnt_d  = '0;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            default: begin
                state_d    = SCAN;
                dwell_d    = '0;
                col_d      = 4'b1110;
                cnt_d      = '0;
                key_held_d = 1'b0;
            end
        endcase
    end

    // State, counters, synchroniser and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_meta_q  <= 4'b1111;
            row_s_q     <= 4'b1111;
            state_q     <= SCAN;
            dwell_q     <= '0;
            col_q       <= 4'b1110;
            cap_q       <= 4'b1111;
            cnt_q       <= '0;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
`ifdef KEYPAD_SCANNER_REPEAT_EN
            rep_cnt_q   <= '0;
`endif
        end else begin
            row_meta_q  <= kp.row;
            row_s_q     <= row_meta_q;
            state_q     <= state_d;
            dwell_q     <= dwell_d;
            col_q       <= col_d;
            cap_q       <= cap_d;
            cnt_q       <= cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
`ifdef KEYPAD_SCANNER_REPEAT_EN
            rep_cnt_q   <= rep_cnt_d;
`endif
        end
    end

    assign kp.col       = col_q;
    assign kp.key_code  = key_code_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: keypad modelled from col, outputs compared every cycle
// against a behavioural reference, plus literal expectations for the directed scenarios.
`timescale 1ns/1ps
module tb_keypad_scanner;

    localparam int SD = 4;
    localparam int DC = 8;
    localparam int RC = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   strobes = 0;
    bit   cmp_en = 1'b0;

    keypad_scanner_if kif();

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DC), .REPEAT_CNT(RC)) dut (
        .clk   (clk),
        .reset (reset),
        .kp    (kif.master)
    );

    always #5 clk = ~clk;

    // Keypad: a key pulls its row low while its column is driven low.
    bit         k1_on = 1'b0, k2_on = 1'b0, g_on = 1'b0;
    int         k1_c = 0, k1_r = 0, k2_c = 0, k2_r = 0, g_c = 0;
    logic [3:0] g_pat = 4'b1111;
    logic [3:0] row_drv;

    always_comb begin
        row_drv = 4'b1111;
        if (k1_on && kif.col[k1_c] == 1'b0) row_drv[k1_r] = 1'b0;
        if (k2_on && kif.col[k2_c] == 1'b0) row_drv[k2_r] = 1'b0;
        if (g_on && kif.col[g_c] == 1'b0)   row_drv = row_drv & g_pat;
    end
    assign kif.row = row_drv;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: column index, phase (walking / confirming / latched) and run lengths.
    int         m_idx, m_wait, m_phase, m_run, m_quiet, m_rep;
    logic [3:0] m_pat, m_code, m_sy1, m_sy2;
    bit         m_valid, m_held;

    function automatic int zeros(input logic [3:0] p);
        int n = 0;
        for (int i = 0; i < 4; i++) if (!p[i]) n++;
        return n;
    endfunction

    function automatic int zpos(input logic [3:0] p);
        for (int i = 0; i < 4; i++) if (!p[i]) return i;
        return 0;
    endfunction

    task automatic m_reset();
        m_idx = 0; m_wait = 0; m_phase = 0; m_run = 0; m_quiet = 0; m_rep = 0;
        m_pat = 4'hF; m_code = 4'h0; m_sy1 = 4'hF; m_sy2 = 4'hF;
        m_valid = 1'b0; m_held = 1'b0;
    endtask

    task automatic m_step(input logic [3:0] rin);
        logic [3:0] rs;
        rs = m_sy2;
        m_valid = 1'b0;
        if (m_phase == 0) begin
            if (m_wait == SD - 1) begin
                m_wait = 0;
                if (zeros(rs) == 1) begin
                    m_phase = 1; m_pat = rs; m_run = 0;
                end else begin
                    m_idx = (m_idx + 1) % 4;
                end
            end else begin
                m_wait++;
            end
        end else if (m_phase == 1) begin
            if (rs == m_pat) begin
                m_run++;
                if (m_run == DC) begin
                    m_phase = 2;
                    m_code  = {2'(m_idx), 2'(zpos(m_pat))};
                    m_valid = 1'b1; m_held = 1'b1; m_quiet = 0; m_rep = 0;
                end
            end else begin
                m_phase = 0; m_idx = (m_idx + 1) % 4; m_wait = 0;
            end
        end else begin
`ifdef KEYPAD_SCANNER_REPEAT_EN
            if (rs == m_pat) begin
                m_rep++;
                if (m_rep == RC) begin m_valid = 1'b1; m_rep = 0; end
            end else begin
                m_rep = 0;
            end
`endif
            m_quiet = (rs == 4'hF) ? m_quiet + 1 : 0;
            if (m_quiet == DC) begin
                m_phase = 0; m_idx = (m_idx + 1) % 4; m_wait = 0; m_held = 1'b0;
            end
        end
        m_sy2 = m_sy1;
        m_sy1 = rin;
    endtask

    function automatic logic [3:0] m_col();
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << m_idx);
    endfunction

    initial begin
        m_reset();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) m_reset();
            else m_step(kif.row);
        end
    end

    always @(posedge clk) if (kif.key_valid === 1'b1) strobes <= strobes + 1;

    // Every-cycle comparison against the reference model.
    always @(negedge clk) begin
        if (cmp_en && !reset) begin
            chk("col",       kif.col,       m_col());
            chk("key_code",  kif.key_code,  m_code);
            chk("key_valid", kif.key_valid, m_valid);
            chk("key_held",  kif.key_held,  m_held);
        end
    end

    task automatic wait_valid(input int lim, output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (kif.key_valid !== 1'b1 && n < lim);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int n, s0, hold, mode;
        cycles(3);
        #1 reset = 1'b0;
        cmp_en = 1'b1;

        // Idle scanning.
        s0 = strobes;
        cycles(4);
        chk("idle_col_after4", kif.col, 4'b1101);
        cycles(12);
        chk("idle_col_wrap", kif.col, 4'b1110);
        chk("idle_code", kif.key_code, 4'h0);
        cycles(24);
        chk("idle_no_strobe", 8'(strobes - s0), 8'd0);

        // Single press col1/row2, held 100 cycles.
        k1_c = 1; k1_r = 2; k1_on = 1'b1;
        wait_valid(100, n);
        chk("press_seen", kif.key_valid, 1'b1);
        chk("press_code", kif.key_code, 4'h6);
        chk("press_held", kif.key_held, 1'b1);
        chk("press_col", kif.col, 4'b1101);
        s0 = strobes;
        cycles(80);
`ifdef KEYPAD_SCANNER_REPEAT_EN
        chk("hold_strobes", 8'(strobes - s0), 8'd5);
`else
        chk("hold_strobes", 8'(strobes - s0), 8'd1);
`endif
        cycles(20);
        chk("hold_col_frozen", kif.col, 4'b1101);
        k1_on = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (kif.key_held === 1'b1 && n < 40);
        chk("release_latency", 8'(n), 8'd10);
        chk("release_col", kif.col, 4'b1011);
        chk("release_code", kif.key_code, 4'h6);

        // Bouncing key col3/row0.
        k1_c = 3; k1_r = 0;
        s0 = strobes;
        for (int i = 0; i < 20; i++) begin
            k1_on = ~k1_on;
            cycles(3);
        end
        k1_on = 1'b0;
        cycles(12);
        chk("bounce_no_strobe", 8'(strobes - s0), 8'd0);
        chk("bounce_code", kif.key_code, 4'h6);

        // Ghosting: two rows low on col0.
        g_c = 0; g_pat = 4'b1100; g_on = 1'b1;
        s0 = strobes;
        cycles(40);
        g_on = 1'b0;
        chk("ghost_no_strobe", 8'(strobes - s0), 8'd0);
        chk("ghost_no_hold", kif.key_held, 1'b0);

        // Reset while pressed, then re-detect with the key still down.
        k1_c = 1; k1_r = 2; k1_on = 1'b1;
        wait_valid(100, n);
        chk("press2_seen", kif.key_valid, 1'b1);
        cycles(5);
        #1 reset = 1'b1;
        #1;
        chk("rst_held", kif.key_held, 1'b0);
        chk("rst_code", kif.key_code, 4'h0);
        chk("rst_col", kif.col, 4'b1110);
        chk("rst_valid", kif.key_valid, 1'b0);
        @(negedge clk);
        #1 reset = 1'b0;
        wait_valid(60, n);
        chk("rearm_latency", 8'(n), 8'd16);
        chk("rearm_code", kif.key_code, 4'h6);
        s0 = strobes;
        cycles(12);
        chk("rearm_one_strobe", 8'(strobes - s0), 8'd1);
        k1_on = 1'b0;
        cycles(30);

        // Randomized presses, bounces, second keys, ghosts and one reset.
        for (int it = 0; it < 25; it++) begin
            k1_c = $urandom_range(0, 3);
            k1_r = $urandom_range(0, 3);
            mode = $urandom_range(0, 3);
            hold = $urandom_range(20, 120);
            if (mode == 1) begin
                for (int j = 0; j < 8; j++) begin
                    k1_on = ~k1_on;
                    cycles($urandom_range(1, 6));
                end
            end
            k1_on = 1'b1;
            if (mode == 3) begin
                g_c = k1_c; g_pat = 4'($urandom_range(0, 15)); g_on = 1'b1;
            end
            cycles(hold / 2);
            if (mode == 2) begin
                k2_c = $urandom_range(0, 3); k2_r = $urandom_range(0, 3); k2_on = 1'b1;
            end
            if (it == 12) begin
                #1 reset = 1'b1;
                @(negedge clk);
                #1 reset = 1'b0;
            end
            cycles(hold / 2);
            k1_on = 1'b0;
            cycles($urandom_range(0, 12));
            k2_on = 1'b0; g_on = 1'b0;
            cycles($urandom_range(20, 60));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Column-driving scanner for the 4x4 matrix push-button keypad. It is the driving end of the row-sensing key decoders.
- Walks a single active-low column across col[3:0] and samples the active-low row[3:0] lines.
- Debounces each press and release.
- Emits one 4-bit key code plus a one-cycle key_valid strobe per press, for the vending-machine control logic.

Parameters:
- SCAN_DIV, 4, clock cycles each column is driven before advancing; minimum 2
- DEBOUNCE_CNT, 8, consecutive stable cycles required to accept a press or a release; minimum 1
- REPEAT_CNT, 64, cycles between auto-repeat strobes; used only with the optional feature

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- row  input  4  keypad row lines, active-low, asynchronous to clk
- col  output  4  keypad column drive; exactly one bit low at all times
- key_code  output  4  {col_idx[1:0], row_idx[1:0]} of the last accepted key
- key_valid  output  1  one-cycle strobe when key_code is updated or repeated
- key_held  output  1  high while an accepted key remains pressed

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-high, on port reset.
- Reset values: col=4'b1110, key_code=4'h0, key_valid=0, key_held=0. State is SCAN; all counters are 0; the synchroniser is loaded with 4'b1111.
- Synchroniser: row passes through 2 flops before any use; call the result row_s. All decisions use row_s.
- Column order: 1110 (idx0) -> 1101 (idx1) -> 1011 (idx2) -> 0111 (idx3) -> wrap to 1110.
- row_idx: position of the single 0 in row_s (1110=0, 1101=1, 1011=2, 0111=3).
- Valid pattern: row_s containing exactly one 0. Zero or multiple zeros count as "no key". Multiple zeros (ghosting) never enter DEBOUNCE.
- State SCAN:
  - dwell counter runs 0..SCAN_DIV-1.
  - Sampling happens only at dwell==SCAN_DIV-1.
  - If row_s is a valid pattern, capture it and go to DEBOUNCE; col stays frozen.
  - Otherwise advance col and clear dwell.
- State DEBOUNCE:
  - Each cycle, compare row_s to the captured pattern.
  - On a mismatch, return to SCAN with col advanced and dwell=0; no strobe.
  - After DEBOUNCE_CNT consecutive matches, go to PRESSED.
  - On that transition edge, key_code is set to {col_idx,row_idx}, key_valid=1 for exactly one cycle, and key_held=1.
- State PRESSED:
  - col stays frozen.
  - Release counter increments on each cycle where row_s==4'b1111. Any other value clears it.
  - When the counter reaches DEBOUNCE_CNT, go to SCAN with col advanced, dwell=0, and key_held=0.
  - key_code holds its last value indefinitely. No strobe is issued on release.
- Only one key is tracked at a time. A second key pressed while in PRESSED is ignored, and it delays release acceptance until row_s returns to 1111.
- Press latency (valid key already stable when its column is sampled): key_valid asserts DEBOUNCE_CNT+1 cycles after the sampling cycle.
- Reset mid-operation: all outputs return to their reset values immediately (asynchronously), including during PRESSED. No strobe is emitted on deassertion.
- Counters are sized for their parameters. No wrap is possible, because each counter stops at its terminal value.

Optional Feature:
- Macro: KEYPAD_SCANNER_REPEAT_EN.
- Defined:
  - In PRESSED, a repeat counter runs while row_s equals the captured pattern.
  - Every REPEAT_CNT cycles it re-pulses key_valid for one cycle, with key_code unchanged.
  - It clears on any deviation from the captured pattern and on leaving PRESSED.
- Undefined: no repeat counter is built, and key_valid pulses exactly once per accepted press.

Test Plan (SCAN_DIV=4, DEBOUNCE_CNT=8, REPEAT_CNT=16; bench models the keypad by driving row from col):
- Idle:
  - Stimulus: reset pulse, then row=4'b1111 for 40 cycles.
  - Required: col cycles 1110,1101,1011,0111 every 4 cycles and wraps; key_valid never asserts; key_code=0.
- Single press, key at col idx1 / row idx2:
  - Stimulus: row=4'b1011 whenever col=1101; hold 100 cycles.
  - Required: exactly one key_valid, key_code=4'h6, key_held=1, col frozen at 1101.
  - Then release (row=1111): key_held drops 8 cycles after row_s is 1111, and scanning resumes at 1011.
- Bounce:
  - Stimulus: key idx3/idx0 (row=1110 when col=0111) toggling every 3 cycles for 60 cycles.
  - Required: no key_valid; key_code unchanged; scanning continues.
- Ghosting:
  - Stimulus: row=4'b1100 when col=1110.
  - Required: no DEBOUNCE entry, no strobe; col keeps rotating.
- Reset mid-press:
  - Stimulus: assert reset while key_held=1 with key_code=4'h6.
  - Required: same cycle key_held=0, key_code=0, col=1110; after release of reset and with the key still held, a fresh press is detected and exactly one strobe is issued.
- Repeat (macro defined):
  - Stimulus: hold key 4'h6 for 80 cycles after acceptance.
  - Required: key_valid re-pulses every 16 cycles with key_code=4'h6.
  - Undefined build: only the single initial pulse.
